serial_subtractor: RTL and testbench

Parametrised multi-bit subtractor that computes D = A − B − Bin over WIDTH bits. It processes DIGIT bits per clock, LSB-first, and keeps the borrow in a flip-flop between digit steps. A start/busy/done handshake controls each operation. It replaces single-bit combinational borrow chains wherever wide operands must be subtracted with small area, and it also reports signed overflow.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_sub_digit.sv | 32 +++
 rtl/serial_subtractor.sv | 158 +++++++++++++++
 tb/tb_serial_subtractor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor.
// Contents: FSM state encoding (value 3 is unused and treated as IDLE) and a
// configuration sanity helper checking that DIGIT divides WIDTH.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_RSVD = 2'd3
    } state_e;

    // True when a WIDTH/DIGIT pairing is usable by the serial datapath.
    function automatic bit digit_cfg_ok(input int width, input int digit);
        return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// sub_digit: combinational DIGIT-bit ripple-borrow subtract slice.
// Ports:
//   a_i, b_i  DIGIT-bit operand slices (minuend, subtrahend)
//   bin_i     borrow into the least significant bit
//   d_o       DIGIT-bit difference slice
//   bout_o    borrow out of the most significant bit
module sub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             bin_i,
    output logic [DIGIT-1:0] d_o,
    output logic             bout_o
);

    logic [DIGIT:0] br_s;

    // Ripple the borrow from LSB to MSB across the slice.
    always_comb begin
        br_s    = {(DIGIT+1){1'b0}};
        d_o     = {DIGIT{1'b0}};
        br_s[0] = bin_i;
        for (int i = 0; i < DIGIT; i++) begin
            d_o[i]    = a_i[i] ^ b_i[i] ^ br_s[i];
            // Borrow when a<b, or a==b with a borrow already pending.
            br_s[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & br_s[i]);
        end
        bout_o = br_s[DIGIT];
    end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes D = A - B - Bin over WIDTH bits, DIGIT bits per
// clock LSB-first, with a start/busy/done handshake and signed overflow flag.
// Ports:
//   clk_i     rising-edge clock
//   rst_n_i   synchronous active-low reset
//   start_i   operation request, honoured only in IDLE
//   a_i, b_i  minuend / subtrahend, captured on accepted start
//   bin_i     borrow-in, captured on accepted start
//   busy_o    high in RUN and DONE
//   done_o    one-cycle pulse, results valid
//   d_o       difference mod 2^WIDTH
//   bout_o    final unsigned borrow
//   ovf_o     signed overflow
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] d_o,
    output logic             bout_o,
    output logic             ovf_o
);

    localparam bit CFG_OK = digit_cfg_ok(WIDTH, DIGIT);
    localparam int N      = WIDTH / DIGIT;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if (!CFG_OK) begin : g_cfg_check
        $error("serial_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_sr_q, b_sr_q;
    logic               borrow_q;
    logic               a_msb_q, b_msb_q;
    logic [WIDTH-1:0]   d_q;
    logic               bout_q, ovf_q, done_q, busy_q;

    logic               run_s, load_s;
    logic [DIGIT-1:0]   slice_d_s;
    logic               slice_bout_s;
    logic [WIDTH-1:0]   a_sr_d, b_sr_d, acc_d;
    logic               ovf_d;

    // The reserved encoding behaves exactly like IDLE.
    assign run_s  = (state_q == ST_RUN);
    assign load_s = (state_q != ST_RUN) && (state_q != ST_DONE) && start_i;

    sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
        .a_i    (a_sr_q[DIGIT-1:0]),
        .b_i    (b_sr_q[DIGIT-1:0]),
        .bin_i  (borrow_q),
        .d_o    (slice_d_s),
        .bout_o (slice_bout_s)
    );

    assign a_sr_d = a_sr_q >> DIGIT;
    assign b_sr_d = b_sr_q >> DIGIT;

    // Only the upper WIDTH-DIGIT accumulator bits need storage; the newest
    // slice is always taken straight from the subtract slice.
    if (DIGIT == WIDTH) begin : g_acc_full
        assign acc_d = slice_d_s;
    end else begin : g_acc_part
        logic [WIDTH-DIGIT-1:0] acc_q;

        assign acc_d = {slice_d_s, acc_q};

        // Accumulator shifts in result slices from the top during RUN.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                acc_q <= {(WIDTH-DIGIT){1'b0}};
            end else if (load_s) begin
                acc_q <= {(WIDTH-DIGIT){1'b0}};
            end else if (run_s) begin
                acc_q <= acc_d[WIDTH-1:DIGIT];
            end else begin
                acc_q <= acc_q;
            end
        end
    end

    // Overflow only when operand signs differ and the result sign leaves A's.
    assign ovf_d = (a_msb_q ^ b_msb_q) & (acc_d[WIDTH-1] ^ a_msb_q);

    // Control FSM, digit counter, operand shift registers and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            a_sr_q   <= {WIDTH{1'b0}};
            b_sr_q   <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            d_q      <= {WIDTH{1'b0}};
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    a_sr_q   <= a_sr_d;
                    b_sr_q   <= b_sr_d;
                    borrow_q <= slice_bout_s;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        d_q     <= acc_d;
                        bout_q  <= slice_bout_s;
                        ovf_q   <= ovf_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= {CNT_W{1'b0}};
                        a_sr_q   <= a_i;
                        b_sr_q   <= b_i;
                        borrow_q <= bin_i;
                        a_msb_q  <= a_i[WIDTH-1];
                        b_msb_q  <= b_i[WIDTH-1];
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign d_o    = d_q;
    assign bout_o = bout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: four instances covering
// (8,1), (4,1), (4,2) and (16,16); table vectors, exhaustive 4-bit sweeps and
// hand-written handshake/reset sequences, with a scoreboard queue of results.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  start;
    logic [15:0] a, b;
    logic        bin;

    logic [3:0]  busy_w, done_w, bout_w, ovf_w;
    logic [7:0]  d8;
    logic [3:0]  d4a, d4b;
    logic [15:0] d16;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] d;
        logic        bout;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          sel;
        logic [15:0] a, b;
        logic        bin;
        logic [15:0] d;
        logic        bout;
        logic        ovf;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[8];

    int w_of[4] = '{8, 4, 4, 16};
    int n_of[4] = '{8, 4, 2, 1};

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_w8 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start[0]), .a_i(a[7:0]), .b_i(b[7:0]),
        .bin_i(bin), .busy_o(busy_w[0]), .done_o(done_w[0]), .d_o(d8),
        .bout_o(bout_w[0]), .ovf_o(ovf_w[0]));

    serial_subtractor #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start[1]), .a_i(a[3:0]), .b_i(b[3:0]),
        .bin_i(bin), .busy_o(busy_w[1]), .done_o(done_w[1]), .d_o(d4a),
        .bout_o(bout_w[1]), .ovf_o(ovf_w[1]));

    serial_subtractor #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start[2]), .a_i(a[3:0]), .b_i(b[3:0]),
        .bin_i(bin), .busy_o(busy_w[2]), .done_o(done_w[2]), .d_o(d4b),
        .bout_o(bout_w[2]), .ovf_o(ovf_w[2]));

    serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_w16 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start[3]), .a_i(a), .b_i(b),
        .bin_i(bin), .busy_o(busy_w[3]), .done_o(done_w[3]), .d_o(d16),
        .bout_o(bout_w[3]), .ovf_o(ovf_w[3]));

    function automatic logic [15:0] dut_d(input int sel);
        case (sel)
            0:       return {8'h00, d8};
            1:       return {12'h000, d4a};
            2:       return {12'h000, d4b};
            default: return d16;
        endcase
    endfunction

    // Reference: plain integer arithmetic, overflow from the signed range.
    function automatic exp_t model(input int w, input int av, input int bv, input int bi);
        exp_t e;
        int full, sa, sb, sres;
        full   = av - bv - bi;
        e.d    = 16'(full & ((1 << w) - 1));
        e.bout = (full < 0);
        sa     = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sb     = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        sres   = sa - sb - bi;
        e.ovf  = (sres < -(1 << (w - 1))) || (sres > ((1 << (w - 1)) - 1));
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One operation on instance sel; starts and ends on a falling edge.
    task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                          input logic bi, input bit inject, input exp_t e);
        exp_t got;
        int   k;
        bit   seen;
        sb_q.push_back(e);
        a = av; b = bv; bin = bi;
        start[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[sel] = 1'b0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
        check("busy_rise", {31'd0, busy_w[sel]}, 32'd1);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            // A second request during RUN must be ignored.
            start[sel] = (inject && k == 2) ? 1'b1 : 1'b0;
            @(posedge clk);
            @(negedge clk);
            k++;
            if (done_w[sel]) seen = 1'b1;
        end
        start[sel] = 1'b0;
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            if (sb_q.size() > 0) got = sb_q.pop_front();
        end else begin
            check("latency", k, n_of[sel]);
            check("busy_in_done", {31'd0, busy_w[sel]}, 32'd1);
            if (sb_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                got = sb_q.pop_front();
                check("result", {14'd0, ovf_w[sel], bout_w[sel], dut_d(sel)},
                      {14'd0, got.ovf, got.bout, got.d});
            end
            @(posedge clk);
            @(negedge clk);
            check("busy_fall", {30'd0, busy_w[sel], done_w[sel]}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   dn, first_dn, gap_ok, last_dn;

        tbl[0] = '{sel:0, a:16'h0005, b:16'h0003, bin:1'b0, d:16'h0002, bout:1'b0, ovf:1'b0};
        tbl[1] = '{sel:0, a:16'h0000, b:16'h0001, bin:1'b0, d:16'h00FF, bout:1'b1, ovf:1'b0};
        tbl[2] = '{sel:0, a:16'h0080, b:16'h0001, bin:1'b0, d:16'h007F, bout:1'b0, ovf:1'b1};
        tbl[3] = '{sel:0, a:16'h0010, b:16'h000F, bin:1'b1, d:16'h0000, bout:1'b0, ovf:1'b0};
        tbl[4] = '{sel:0, a:16'h007F, b:16'h00FF, bin:1'b0, d:16'h0080, bout:1'b1, ovf:1'b1};
        tbl[5] = '{sel:1, a:16'h0008, b:16'h0001, bin:1'b0, d:16'h0007, bout:1'b0, ovf:1'b1};
        tbl[6] = '{sel:2, a:16'h0003, b:16'h0005, bin:1'b1, d:16'h000D, bout:1'b1, ovf:1'b0};
        tbl[7] = '{sel:3, a:16'h1234, b:16'h4321, bin:1'b0, d:16'hCF13, bout:1'b1, ovf:1'b0};

        // Reset held 3 cycles with start asserted on every instance.
        rst_n = 1'b0; start = 4'hF; a = 16'hFFFF; b = 16'h0001; bin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {28'd0, busy_w}, 32'd0);
        check("rst_done", {28'd0, done_w}, 32'd0);
        check("rst_flags", {24'd0, bout_w, ovf_w}, 32'd0);
        for (int s = 0; s < 4; s++) check("rst_d", {16'd0, dut_d(s)}, 32'd0);
        start = 4'h0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", {28'd0, busy_w}, 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            e.d = tbl[i].d; e.bout = tbl[i].bout; e.ovf = tbl[i].ovf;
            run_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].bin, 1'b0, e);
        end

        // Start pulsed during RUN with other operands is ignored.
        e.d = 16'h0002; e.bout = 1'b0; e.ovf = 1'b0;
        run_op(0, 16'h0005, 16'h0003, 1'b0, 1'b1, e);

        // Reset mid-RUN: operation abandoned, outputs cleared.
        a = 16'h0080; b = 16'h0001; bin = 1'b0; start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_w[0]) dn++;
        end
        check("abort_no_done", dn, 32'd0);
        check("abort_outputs", {20'd0, busy_w[0], done_w[0], bout_w[0], ovf_w[0], d8}, 32'd0);

        // Exhaustive 4-bit sweeps, DIGIT=1 and DIGIT=2.
        for (int s = 1; s <= 2; s++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    for (int bi = 0; bi < 2; bi++) begin
                        e = model(4, av, bv, bi);
                        run_op(s, 16'(av), 16'(bv), 1'(bi), 1'b0, e);
                    end
                end
            end
        end

        // Full-width digit with start held: accepted every 3 cycles.
        a = 16'h1234; b = 16'h4321; bin = 1'b0; start[3] = 1'b1;
        dn = 0; first_dn = -1; last_dn = -1; gap_ok = 1;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 8) start[3] = 1'b0;
            if (done_w[3]) begin
                dn++;
                if (first_dn < 0) first_dn = c;
                if (last_dn >= 0 && (c - last_dn) != 3) gap_ok = 0;
                last_dn = c;
                check("b2b_result", {15'd0, bout_w[3], d16}, {15'd0, 1'b1, 16'hCF13});
            end
        end
        start[3] = 1'b0;
        check("b2b_count", dn, 32'd3);
        check("b2b_first", first_dn, 32'd1);
        check("b2b_gap", gap_ok, 32'd1);
        @(negedge clk);
        check("b2b_idle", {31'd0, busy_w[3]}, 32'd0);

        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
